// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared definitions for the note sequencer slice.
//   state_t    - sequencer FSM states
//   NOTE_W     - width of the note index carried in each song ROM word
//   NOTE_REST  - note index meaning rest / blank display
//   DUR_END    - duration value marking the end of the song
//   DUR_LSB / note_lsb() - field offsets inside a rom_data word {note, duration}
package note_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    PLAY,
    DONE
  } state_t;

  localparam int unsigned NOTE_W = 6;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam int unsigned DUR_END = 0;

  // Duration occupies the low bits of a ROM word; the note sits directly above.
  localparam int unsigned DUR_LSB = 0;

  function automatic int unsigned note_lsb(input int unsigned dur_w);
    return DUR_LSB + dur_w;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: song ROM bus between the sequencer and its sibling ROM.
//   rom_addr - address issued by the sequencer (registered on its side)
//   rom_data - {note, duration} word, valid one cycle after rom_addr changes
// Modports: master = sequencer side, slave = synchronous ROM side.
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DUR_W  = 6
) ();

  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a song held in an external synchronous ROM.
// Each ROM word is {note, duration}; a note is held for `duration` beats while
// play is high, then the next address is fetched. duration == 0 ends the song.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   play       - level: 1 advances the song, 0 pauses it
//   restart    - one-cycle pulse, return to song start (highest priority)
//   beat       - one-cycle tick per beat
//   rom        - note_sequencer_if.master: rom_addr out, rom_data in
//   note       - current note index, 0 = rest / blank
//   new_note   - one-cycle pulse when a ROM entry is loaded into note
//   song_done  - end-of-song indication
//
// Build option:
//   NOTE_SEQ_LOOP_EN - when defined, the end marker wraps back to address 0,
//                      pulses song_done for one cycle and keeps playing.
//                      When undefined, the end marker parks the sequencer in
//                      DONE with song_done held high until restart or reset.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DUR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              restart,
  input  logic              beat,
  note_sequencer_if.master  rom,
  output logic [NOTE_W-1:0] note,
  output logic              new_note,
  output logic              song_done
);

  localparam int unsigned NOTE_LSB = note_lsb(DUR_W);

  state_t              state_q;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [NOTE_W-1:0]   note_q;
  logic [NOTE_W-1:0]   note_nxt;
  logic [DUR_W-1:0]    dur_cnt_q;
  logic [DUR_W-1:0]    dur_cnt_nxt;
  logic                new_note_q;
  logic                new_note_nxt;
  logic                done_q;
  logic                done_nxt;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                end_marker;
  logic                advance;
  logic                last_beat;

  assign rom_note   = rom.rom_data[NOTE_LSB +: NOTE_W];
  assign rom_dur    = rom.rom_data[DUR_LSB +: DUR_W];
  assign end_marker = (rom_dur == DUR_W'(DUR_END));

  // Beats only count while playing; the final counted beat of an entry moves on.
  assign advance    = beat & play;
  assign last_beat  = advance && (dur_cnt_q == DUR_W'(1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      note_q     <= '0;
      dur_cnt_q  <= '0;
      new_note_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      addr_q     <= addr_nxt;
      note_q     <= note_nxt;
      dur_cnt_q  <= dur_cnt_nxt;
      new_note_q <= new_note_nxt;
      done_q     <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    if (restart) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play) state_nxt = FETCH;
        end
        FETCH: begin
          // Address is already on the bus; this cycle lets the ROM register it.
          state_nxt = WAIT_ROM;
        end
        WAIT_ROM: begin
          if (end_marker) begin
`ifdef NOTE_SEQ_LOOP_EN
            state_nxt = FETCH;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = PLAY;
          end
        end
        PLAY: begin
          if (last_beat) state_nxt = FETCH;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    addr_nxt     = addr_q;
    note_nxt     = note_q;
    dur_cnt_nxt  = dur_cnt_q;
    new_note_nxt = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
    done_nxt     = 1'b0;
`else
    done_nxt     = done_q;
`endif

    if (restart) begin
      addr_nxt    = '0;
      note_nxt    = NOTE_REST;
      dur_cnt_nxt = '0;
      done_nxt    = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_ROM: begin
          if (end_marker) begin
            note_nxt    = NOTE_REST;
            dur_cnt_nxt = '0;
            done_nxt    = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
            addr_nxt    = '0;
`endif
          end else begin
            // Rests (note 0) load and pulse exactly like audible notes.
            note_nxt     = rom_note;
            dur_cnt_nxt  = rom_dur;
            new_note_nxt = 1'b1;
          end
        end
        PLAY: begin
          if (advance) begin
            dur_cnt_nxt = dur_cnt_q - 1'b1;
            // Address width sets the wrap point, so overflow rolls to 0.
            if (last_beat) addr_nxt = addr_q + 1'b1;
          end
        end
        DONE: begin
          note_nxt = NOTE_REST;
          done_nxt = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign rom.rom_addr = addr_q;
  assign note         = note_q;
  assign new_note     = new_note_q;
  assign song_done    = done_q;

endmodule
